// File: rtl/line_window_v_fp16.sv
// Vertical WINDOW_HEIGHT x 1 fp16 column-window generator with zero padding at top and bottom and an end-of-frame flush.
// One-cycle registered latency; no backpressure: upstream holds valid_i low while busy_o is high, and pixels offered during flush are dropped.
module line_window_v_fp16 #(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 1,
  parameter int WINDOW_HEIGHT = 3,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic [15:0]             col_i,
  input  logic [15:0]             row_i,
  input  logic                    valid_i,
  output logic                    busy_o,
  output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o
);

  localparam int R  = (WINDOW_HEIGHT - 1) / 2;
  localparam int NB = WINDOW_HEIGHT - 1;
  localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int FW = (R > 1) ? $clog2(R) : 1;

  if (WINDOW_WIDTH != 1) begin : g_bad_width
    $error("line_window_v_fp16: WINDOW_WIDTH must be 1");
  end
  if ((WINDOW_HEIGHT % 2) == 0 || WINDOW_HEIGHT < 3 || WINDOW_HEIGHT > 7) begin : g_bad_height
    $error("line_window_v_fp16: WINDOW_HEIGHT must be odd in 3..7");
  end
  if (IMAGE_HEIGHT < WINDOW_HEIGHT) begin : g_bad_image
    $error("line_window_v_fp16: IMAGE_HEIGHT must be >= WINDOW_HEIGHT");
  end

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t                  state;
  logic [2:0]              fill_cnt;
  logic [AW-1:0]           flush_col;
  logic [FW-1:0]           flush_row;

  logic [FP_WIDTH_REG-1:0] lbuf [NB][IMAGE_WIDTH];
  logic [FP_WIDTH_REG-1:0] rd [NB];
  logic [FP_WIDTH_REG-1:0] win_in [WINDOW_HEIGHT];
  logic [FP_WIDTH_REG-1:0] win_fl [WINDOW_HEIGHT];
  logic [AW-1:0]           rd_addr;
  logic                    accept, sof, last_pix, fill_ready, emit_in;

  always_comb begin
    accept     = valid_i && (state != FLUSH);
    sof        = accept && (row_i == 16'd0) && (col_i == 16'd0);
    last_pix   = (row_i == 16'(IMAGE_HEIGHT - 1)) && (col_i == 16'(IMAGE_WIDTH - 1));
    fill_ready = (row_i >= 16'(R)) && (fill_cnt >= 3'(R));
    emit_in    = accept && !sof && ((state == STREAM) || ((state == FILL) && fill_ready));
    rd_addr    = (state == FLUSH) ? flush_col : col_i[AW-1:0];
    for (int k = 0; k < NB; k++) begin
      rd[k] = lbuf[k][rd_addr];
    end
  end

  // Top padding is decided from the centre row, so stale buffer rows from an earlier frame never leak in.
  always_comb begin
    for (int j = 0; j < NB; j++) begin
      win_in[j] = ((int'({16'd0, row_i}) + j) < 2 * R) ? '0 : rd[j];
    end
    win_in[WINDOW_HEIGHT-1] = data_i;
  end

  // During flush, buffer k holds image row IMAGE_HEIGHT-NB+k; window rows past the bottom stay zero.
  always_comb begin
    for (int j = 0; j < WINDOW_HEIGHT; j++) begin
      win_fl[j] = '0;
      for (int k = 0; k < NB; k++) begin
        if (k == int'(flush_row) + j) win_fl[j] = rd[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int k = 0; k < NB - 1; k++) begin
        lbuf[k][rd_addr] <= rd[k+1];
      end
      lbuf[NB-1][rd_addr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= FILL;
      fill_cnt  <= '0;
      flush_col <= '0;
      flush_row <= '0;
      valid_o   <= 1'b0;
      busy_o    <= 1'b0;
      col_o     <= '0;
      row_o     <= '0;
      for (int j = 0; j < WINDOW_HEIGHT; j++) window_o[j][0] <= '0;
    end else begin
      valid_o <= 1'b0;
      if (state == FLUSH) begin
        valid_o <= 1'b1;
        col_o   <= 16'(flush_col);
        row_o   <= 16'(IMAGE_HEIGHT - R) + 16'(flush_row);
        for (int j = 0; j < WINDOW_HEIGHT; j++) window_o[j][0] <= win_fl[j];
        if (flush_col == AW'(IMAGE_WIDTH - 1)) begin
          flush_col <= '0;
          if (flush_row == FW'(R - 1)) begin
            flush_row <= '0;
            state     <= FILL;
            busy_o    <= 1'b0;
            fill_cnt  <= '0;
          end else begin
            flush_row <= flush_row + 1'b1;
          end
        end else begin
          flush_col <= flush_col + 1'b1;
        end
      end else begin
        if (emit_in) begin
          valid_o <= 1'b1;
          col_o   <= col_i;
          row_o   <= row_i - 16'(R);
          for (int j = 0; j < WINDOW_HEIGHT; j++) window_o[j][0] <= win_in[j];
        end
        if (sof) begin
          state    <= FILL;
          fill_cnt <= (col_i == 16'(IMAGE_WIDTH - 1)) ? 3'd1 : 3'd0;
        end else if (accept) begin
          if (emit_in && last_pix) begin
            state  <= FLUSH;
            busy_o <= 1'b1;
          end else if (emit_in) begin
            state <= STREAM;
          end
          if ((state == FILL) && (col_i == 16'(IMAGE_WIDTH - 1)) && (fill_cnt < 3'(R))) begin
            fill_cnt <= fill_cnt + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_line_window_v_fp16.sv
// Bench for line_window_v_fp16 on a 4x3 image with a 3-tap column window, against a frame-array reference model.
module tb_line_window_v_fp16;

  localparam int IW = 4;
  localparam int IH = 3;
  localparam int H  = 3;
  localparam int R  = (H - 1) / 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [15:0] col_i = '0;
  logic [15:0] row_i = '0;
  logic        valid_i = 1'b0;
  logic        busy_o;
  logic [15:0] window_o [H][1];
  logic [15:0] col_o;
  logic [15:0] row_o;
  logic        valid_o;

  line_window_v_fp16 #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(1), .WINDOW_HEIGHT(H),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .busy_o(busy_o), .window_o(window_o), .col_o(col_o),
    .row_o(row_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [H-1:0][15:0] w;
    logic [15:0]        r;
    logic [15:0]        c;
  } win_t;

  // Reference model: the current frame's pixels plus a queue of pending flush windows.
  logic [15:0] img [IH][IW];
  win_t        fq[$];
  bit          frame_ok = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          vcount = 0;
  int          bcount = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int rr, input int cc);
    if (rr < 0 || rr >= IH) return 16'h0000;
    return img[rr][cc];
  endfunction

  task automatic model_reset();
    fq.delete();
    frame_ok = 1'b0;
  endtask

  task automatic step(input logic v, input int r, input int c, input logic [15:0] d);
    win_t e;
    logic ev;
    logic eb;
    valid_i = v; row_i = 16'(r); col_i = 16'(c); data_i = d;
    ev = 1'b0;
    e  = '0;
    if (fq.size() > 0) begin
      e  = fq.pop_front();
      ev = 1'b1;
    end else if (v) begin
      img[r][c] = d;
      if (r == 0 && c == 0) begin
        frame_ok = 1'b1;
      end else if (frame_ok && r >= R) begin
        ev  = 1'b1;
        e.r = 16'(r - R);
        e.c = 16'(c);
        for (int j = 0; j < H; j++) e.w[j] = pix(r - 2 * R + j, c);
        if (r == IH - 1 && c == IW - 1) begin
          frame_ok = 1'b0;
          for (int fr = IH - R; fr < IH; fr++) begin
            for (int cc = 0; cc < IW; cc++) begin
              win_t f;
              f.r = 16'(fr);
              f.c = 16'(cc);
              for (int j = 0; j < H; j++) f.w[j] = pix(fr - R + j, cc);
              fq.push_back(f);
            end
          end
        end
      end
    end
    eb = (fq.size() > 0);
    @(posedge clk);
    #1;
    chk("valid_o", valid_o, ev);
    chk("busy_o", busy_o, eb);
    if (ev) begin
      chk("row_o", row_o, e.r);
      chk("col_o", col_o, e.c);
      for (int j = 0; j < H; j++) chk($sformatf("window[%0d]", j), window_o[j][0], e.w[j]);
    end
    if (valid_o === 1'b1) vcount++;
    if (busy_o === 1'b1) bcount++;
  endtask

  // mode 0: test-plan ramp values back-to-back; mode 1: random values with random bubbles.
  task automatic feed_frame(input int last_row, input int mode);
    for (int r = 0; r <= last_row; r++) begin
      for (int c = 0; c < IW; c++) begin
        logic [15:0] d;
        if (mode != 0) begin
          repeat ($urandom_range(0, 2)) step(1'b0, $urandom_range(0, IH - 1), $urandom_range(0, IW - 1), 16'($urandom));
          d = 16'($urandom);
        end else begin
          d = 16'h3C00 + 16'(4 * r + c);
        end
        step(1'b1, r, c, d);
        if (mode == 0 && r == 1 && c == 2) begin
          chk("ramp_r1c2_w0", window_o[0][0], 32'h0000);
          chk("ramp_r1c2_w1", window_o[1][0], 32'h3C02);
          chk("ramp_r1c2_w2", window_o[2][0], 32'h3C06);
          chk("ramp_r1c2_row", row_o, 32'd0);
          chk("ramp_r1c2_col", col_o, 32'd2);
        end
        if (mode == 0 && r == 2 && c == 1) begin
          chk("ramp_r2c1_w0", window_o[0][0], 32'h3C01);
          chk("ramp_r2c1_w1", window_o[1][0], 32'h3C05);
          chk("ramp_r2c1_w2", window_o[2][0], 32'h3C09);
          chk("ramp_r2c1_row", row_o, 32'd1);
        end
      end
    end
  endtask

  // Offers a 7E00 pixel on every flush cycle; the DUT must drop all of them.
  task automatic drain(input bit directed);
    for (int i = 0; i < 4 * IW * R && fq.size() > 0; i++) begin
      step(1'b1, 1, 1, 16'h7E00);
      if (directed && valid_o === 1'b1 && col_o === 16'd3) begin
        chk("flush_c3_w0", window_o[0][0], 32'h3C07);
        chk("flush_c3_w1", window_o[1][0], 32'h3C0B);
        chk("flush_c3_w2", window_o[2][0], 32'h0000);
        chk("flush_c3_row", row_o, 32'd2);
      end
    end
    chk("drain_done", fq.size(), 32'd0);
    step(1'b0, 0, 0, 16'h0000);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 32'd0);
    chk({tag, "_busy"}, busy_o, 32'd0);
    chk({tag, "_row"}, row_o, 32'd0);
    chk({tag, "_col"}, col_o, 32'd0);
    for (int j = 0; j < H; j++) chk($sformatf("%s_w%0d", tag, j), window_o[j][0], 32'h0000);
  endtask

  task automatic async_reset();
    valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Ramp frame: back-to-back, with flush and drop checks.
    vcount = 0;
    bcount = 0;
    feed_frame(IH - 1, 0);
    drain(1'b1);
    chk("ramp_valid_count", vcount, 32'd12);
    chk("ramp_busy_cycles", bcount, 32'd4);

    // Random data with bubbles, twice.
    repeat (2) begin
      feed_frame(IH - 1, 1);
      drain(1'b0);
    end

    // Aborted frame after row 1, then a full fresh frame.
    feed_frame(1, 1);
    feed_frame(IH - 1, 1);
    drain(1'b0);

    // Reset mid-stream while a window is being presented.
    feed_frame(1, 1);
    step(1'b1, 2, 0, 16'($urandom));
    chk("pre_reset_valid", valid_o, 32'd1);
    async_reset();
    check_all_zero("mid_stream_rst");
    release_reset();
    feed_frame(IH - 1, 1);
    drain(1'b0);

    // Reset mid-flush.
    feed_frame(IH - 1, 1);
    step(1'b1, 1, 1, 16'h7E00);
    step(1'b1, 1, 1, 16'h7E00);
    chk("pre_flush_rst_busy", busy_o, 32'd1);
    async_reset();
    chk("mid_flush_rst_busy", busy_o, 32'd0);
    chk("mid_flush_rst_valid", valid_o, 32'd0);
    release_reset();
    feed_frame(IH - 1, 0);
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
